pdm_stim_gen: RTL and testbench

PDM_STIM_GEN -- requirements
Module: pdm_stim_gen

---
 rtl/pdm_stim_pkg.sv | 19 +
 rtl/pdm_stim_gen_sd_mod1.sv | 39 +++
 rtl/pdm_stim_gen.sv | 169 ++++++++++++++++
 tb/tb_pdm_stim_gen.sv | 419 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pdm_stim_pkg.sv
// Shared constants for the PDM stimulus generator: source mode encodings
// and the 16-bit Galois LFSR used for the noise source.
package pdm_stim_pkg;

    typedef enum logic [1:0] {
        MODE_CONST  = 2'd0,
        MODE_RAMP   = 2'd1,
        MODE_LFSR   = 2'd2,
        MODE_SQUARE = 2'd3
    } mode_e;

    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        return s[0] ? ((s >> 1) ^ LFSR_TAPS) : (s >> 1);
    endfunction

endpackage

// File: rtl/pdm_stim_gen_sd_mod1.sv
// Single-channel first-order sigma-delta core; the output bit register
// lives in the parent so the next bit is visible combinationally.
module sd_mod1 #(
    parameter int SAMPLE_W = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       upd,
    input  logic signed [SAMPLE_W-1:0] x,
    input  logic                       bit_prev,
    output logic                       bit_nxt
);

    localparam int AW = SAMPLE_W + 2;

    localparam logic signed [AW-1:0] FB_POS =
        {3'b001, {(SAMPLE_W-1){1'b0}}};
    localparam logic signed [AW-1:0] FB_NEG =
        {3'b111, {(SAMPLE_W-1){1'b0}}};

    logic signed [AW-1:0] acc_q;
    logic signed [AW-1:0] acc_next;
    logic signed [AW-1:0] x_ext;
    logic signed [AW-1:0] fb;

    assign x_ext    = {{2{x[SAMPLE_W-1]}}, x};
    assign fb       = bit_prev ? FB_POS : FB_NEG;
    assign acc_next = acc_q + x_ext - fb;
    assign bit_nxt  = ~acc_next[AW-1];

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q <= '0;
        end else if (upd) begin
            acc_q <= acc_next;
        end
    end

endmodule

// File: rtl/pdm_stim_gen.sv
// PDM stimulus generator: divided bit clock, selectable sample source and
// per-channel modulators. Define PDM_STIM_GEN_ONES_CNT_EN for the ones counter.
module pdm_stim_gen
    import pdm_stim_pkg::*;
#(
    parameter int CH_NUM   = 2,
    parameter int DIV      = 25,
    parameter int OSR      = 64,
    parameter int SAMPLE_W = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       en,
    input  logic [1:0]                 mode,
    input  logic signed [SAMPLE_W-1:0] level,
    input  logic signed [SAMPLE_W-1:0] step,
    output logic                       m_clk,
    output logic [CH_NUM-1:0]          m_data,
    output logic                       sample_tick,
    output logic [$clog2(OSR+1)-1:0]   ones_cnt
);

    localparam int DW = $clog2(DIV);
    localparam int RW = $clog2(OSR);
    localparam int OW = $clog2(OSR + 1);

    localparam logic signed [SAMPLE_W-1:0] SMIN =
        {1'b1, {(SAMPLE_W-1){1'b0}}};
    localparam logic signed [SAMPLE_W-1:0] SMAX = ~SMIN;

    function automatic logic signed [SAMPLE_W-1:0] sat_neg(
        input logic signed [SAMPLE_W-1:0] v
    );
        return (v == SMIN) ? SMAX : -v;
    endfunction

    function automatic logic [SAMPLE_W-1:0] lfsr_to_sample(
        input logic [15:0] v
    );
        logic [SAMPLE_W+15:0] wide;
        wide = {v, {SAMPLE_W{1'b0}}};
        return wide[SAMPLE_W+15 -: SAMPLE_W];
    endfunction

    logic [DW-1:0]              div_cnt;
    logic                       div_tc;
    logic                       rise;
    logic                       upd_q;
    logic                       upd;
    logic [RW-1:0]              rise_cnt;
    logic                       win_end;
    logic                       tick;
    logic signed [SAMPLE_W-1:0] sample_q;
    logic signed [SAMPLE_W-1:0] sample_d;
    logic signed [SAMPLE_W-1:0] neg_sample;
    logic [15:0]                lfsr_q;
    logic [15:0]                lfsr_d;
    logic                       phase_q;
    logic                       phase_d;
    logic [CH_NUM-1:0]          bits_nxt;

    assign div_tc  = (div_cnt == DW'(DIV - 1));
    assign rise    = en & div_tc & ~m_clk;
    assign upd     = en & upd_q;
    assign win_end = (rise_cnt == RW'(OSR - 1));
    assign tick    = upd & win_end;

    // Modulators update one clk after the rise so m_data trails m_clk high.
    always_ff @(posedge clk) begin
        if (rst) begin
            div_cnt <= '0;
            m_clk   <= 1'b0;
            upd_q   <= 1'b0;
        end else if (en) begin
            div_cnt <= div_tc ? '0 : div_cnt + DW'(1);
            upd_q   <= rise;
            if (div_tc) begin
                m_clk <= ~m_clk;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rise_cnt    <= '0;
            sample_tick <= 1'b0;
            m_data      <= '0;
        end else begin
            sample_tick <= tick;
            if (upd) begin
                rise_cnt <= win_end ? '0 : rise_cnt + RW'(1);
                m_data   <= bits_nxt;
            end
        end
    end

    assign lfsr_d = lfsr_next(lfsr_q);

    always_comb begin
        sample_d = sample_q;
        phase_d  = phase_q;
        unique case (mode_e'(mode))
            MODE_CONST:  sample_d = level;
            MODE_RAMP:   sample_d = sample_q + step;
            MODE_LFSR:   sample_d = lfsr_to_sample(lfsr_d);
            MODE_SQUARE: begin
                sample_d = phase_q ? sat_neg(level) : level;
                phase_d  = ~phase_q;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sample_q <= '0;
            lfsr_q   <= LFSR_SEED;
            phase_q  <= 1'b0;
        end else if (tick) begin
            sample_q <= sample_d;
            lfsr_q   <= lfsr_d;
            phase_q  <= phase_d;
        end
    end

    assign neg_sample = sat_neg(sample_q);

    for (genvar c = 0; c < CH_NUM; c++) begin : g_ch
        logic signed [SAMPLE_W-1:0] x;
        if (c % 2 == 1) begin : g_odd
            assign x = neg_sample;
        end else begin : g_even
            assign x = sample_q;
        end
        sd_mod1 #(
            .SAMPLE_W (SAMPLE_W)
        ) u_mod (
            .clk      (clk),
            .rst      (rst),
            .upd      (upd),
            .x        (x),
            .bit_prev (m_data[c]),
            .bit_nxt  (bits_nxt[c])
        );
    end

`ifdef PDM_STIM_GEN_ONES_CNT_EN
    logic [OW-1:0] ones_acc;
    logic [OW-1:0] ones_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            ones_acc <= '0;
            ones_q   <= '0;
        end else if (upd) begin
            if (win_end) begin
                ones_q   <= ones_acc + OW'(bits_nxt[0]);
                ones_acc <= '0;
            end else begin
                ones_acc <= ones_acc + OW'(bits_nxt[0]);
            end
        end
    end

    assign ones_cnt = ones_q;
`else
    assign ones_cnt = '0;
`endif

endmodule

// File: tb/tb_pdm_stim_gen.sv
// Self-checking bench for pdm_stim_gen: a reference modulator model feeds
// a scoreboard queue that is drained as the DUT produces bits.
module tb_pdm_stim_gen;

    localparam int CH_NUM   = 2;
    localparam int DIV      = 2;
    localparam int OSR      = 8;
    localparam int SAMPLE_W = 16;
    localparam int OW       = $clog2(OSR + 1);

    logic                       clk = 1'b0;
    logic                       rst = 1'b1;
    logic                       en = 1'b1;
    logic [1:0]                 mode = 2'd0;
    logic signed [SAMPLE_W-1:0] level = '0;
    logic signed [SAMPLE_W-1:0] step = '0;
    logic                       m_clk;
    logic [CH_NUM-1:0]          m_data;
    logic                       sample_tick;
    logic [OW-1:0]              ones_cnt;

    pdm_stim_gen #(
        .CH_NUM   (CH_NUM),
        .DIV      (DIV),
        .OSR      (OSR),
        .SAMPLE_W (SAMPLE_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
        .mode        (mode),
        .level       (level),
        .step        (step),
        .m_clk       (m_clk),
        .m_data      (m_data),
        .sample_tick (sample_tick),
        .ones_cnt    (ones_cnt)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    // reference model state
    int                  m_acc[2];
    logic [1:0]          m_prev;
    logic signed [15:0]  m_s;
    logic [15:0]         m_lfsr;
    bit                  m_phase;
    int                  m_rcnt;
    int                  m_ones_acc;
    int                  m_ones;

    logic [1:0]          q_data[$];
    bit                  q_tick[$];
    logic [OW-1:0]       q_ones[$];
    logic [15:0]         q_sample[$];

    logic                obs_b0[$];
    logic                obs_b1[$];
    logic [15:0]         obs_s[$];
    logic                prev_mclk;
    int                  last_tick;

    function automatic int neg_sat(input logic signed [15:0] v);
        int r;
        r = -int'(v);
        if (r > 32767) r = 32767;
        return r;
    endfunction

    function automatic logic [15:0] galois(input logic [15:0] v);
        logic [15:0] r;
        r = v >> 1;
        if (v[0]) r = r ^ 16'hB400;
        return r;
    endfunction

    task automatic model_reset();
        m_acc[0] = 0;
        m_acc[1] = 0;
        m_prev = 2'b00;
        m_s = '0;
        m_lfsr = 16'hACE1;
        m_phase = 1'b0;
        m_rcnt = 0;
        m_ones_acc = 0;
        m_ones = 0;
        q_data.delete();
        q_tick.delete();
        q_ones.delete();
        q_sample.delete();
        prev_mclk = 1'b0;
        last_tick = -1;
    endtask

    task automatic model_rise();
        int x;
        int fb;
        logic [1:0] b;
        for (int c = 0; c < 2; c++) begin
            x = (c == 0) ? int'(m_s) : neg_sat(m_s);
            fb = m_prev[c] ? 32768 : -32768;
            m_acc[c] = m_acc[c] + x - fb;
            b[c] = (m_acc[c] >= 0);
        end
        m_prev = b;
        q_data.push_back(b);
        m_ones_acc += int'(b[0]);
        if (m_rcnt == OSR - 1) begin
            m_ones = m_ones_acc;
            m_ones_acc = 0;
            m_rcnt = 0;
            m_lfsr = galois(m_lfsr);
            case (mode)
                2'd0: m_s = level;
                2'd1: m_s = m_s + step;
                2'd2: m_s = m_lfsr;
                default: begin
                    m_s = m_phase ? 16'(neg_sat(level)) : level;
                    m_phase = ~m_phase;
                end
            endcase
            q_tick.push_back(1'b1);
        end else begin
            m_rcnt++;
            q_tick.push_back(1'b0);
        end
        q_sample.push_back(m_s);
`ifdef PDM_STIM_GEN_ONES_CNT_EN
        q_ones.push_back(OW'(m_ones));
`else
        q_ones.push_back('0);
`endif
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    task automatic run_rises(input int n);
        int done;
        int budget;
        bit pend;
        logic [1:0] ed;
        bit et;
        logic [OW-1:0] eo;
        logic [15:0] es;
        done = 0;
        budget = n * 4 * DIV + 20;
        pend = 1'b0;
        while (done < n) begin
            @(negedge clk);
            budget--;
            if (budget < 0) begin
                checks++;
                errors++;
                $display("FAIL rise_timeout got %0d of %0d rises", done, n);
                return;
            end
            if (pend) begin
                ed = q_data.pop_front();
                et = q_tick.pop_front();
                eo = q_ones.pop_front();
                es = q_sample.pop_front();
                checks++;
                if (m_data !== ed) begin
                    errors++;
                    $display("FAIL m_data got %b exp %b", m_data, ed);
                end
                checks++;
                if (sample_tick !== et) begin
                    errors++;
                    $display("FAIL sample_tick got %b exp %b", sample_tick, et);
                end
                checks++;
                if (ones_cnt !== eo) begin
                    errors++;
                    $display("FAIL ones_cnt got %0d exp %0d", ones_cnt, eo);
                end
                checks++;
                if (dut.sample_q !== es) begin
                    errors++;
                    $display("FAIL sample got %h exp %h", dut.sample_q, es);
                end
                obs_b0.push_back(m_data[0]);
                obs_b1.push_back(m_data[1]);
                if (et) begin
                    obs_s.push_back(dut.sample_q);
                    if (last_tick >= 0) begin
                        checks++;
                        if (cyc - last_tick != 2 * DIV * OSR) begin
                            errors++;
                            $display("FAIL tick_spacing got %0d exp %0d",
                                     cyc - last_tick, 2 * DIV * OSR);
                        end
                    end
                    last_tick = cyc;
                end
                pend = 1'b0;
                done++;
            end else begin
                checks++;
                if (sample_tick !== 1'b0) begin
                    errors++;
                    $display("FAIL tick_width got %b exp 0", sample_tick);
                end
                if (m_clk === 1'b1 && prev_mclk === 1'b0) begin
                    model_rise();
                    pend = 1'b1;
                end
            end
            prev_mclk = m_clk;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if ({m_clk, m_data, sample_tick} !== '0) begin
            errors++;
            $display("FAIL reset_out got %b exp 0", {m_clk, m_data, sample_tick});
        end
        checks++;
        if (ones_cnt !== '0) begin
            errors++;
            $display("FAIL reset_ones got %0d exp 0", ones_cnt);
        end
        checks++;
        if (dut.lfsr_q !== 16'hACE1) begin
            errors++;
            $display("FAIL reset_lfsr got %h exp ace1", dut.lfsr_q);
        end
    endtask

    task automatic test_clock();
        int t;
        int p;
        rst = 1'b0;
        t = 0;
        while (m_clk !== 1'b1 && t < 20) begin
            @(negedge clk);
            t++;
        end
        checks++;
        if (t != 2) begin
            errors++;
            $display("FAIL first_rise got %0d exp 2", t);
        end
        p = 0;
        while (m_clk !== 1'b0 && p < 20) begin
            @(negedge clk);
            p++;
        end
        while (m_clk !== 1'b1 && p < 20) begin
            @(negedge clk);
            p++;
        end
        checks++;
        if (p != 2 * DIV) begin
            errors++;
            $display("FAIL mclk_period got %0d exp %0d", p, 2 * DIV);
        end
    endtask

    task automatic test_const_zero();
        logic [5:0] pat;
        logic [5:0] want;
        do_reset();
        mode = 2'd0;
        level = '0;
        obs_b0.delete();
        run_rises(2 * OSR);
        want = 6'b110101;
        for (int i = 0; i < 6; i++) pat[5-i] = obs_b0[i];
        checks++;
        if (pat !== want) begin
            errors++;
            $display("FAIL zero_pattern got %b exp %b", pat, want);
        end
`ifdef PDM_STIM_GEN_ONES_CNT_EN
        checks++;
        if (ones_cnt !== OW'(OSR / 2)) begin
            errors++;
            $display("FAIL zero_ones got %0d exp %0d", ones_cnt, OSR / 2);
        end
`endif
    endtask

    task automatic test_const_half();
        int d1;
        do_reset();
        mode = 2'd0;
        level = 16'sh4000;
        obs_b1.delete();
        run_rises(3 * OSR);
        d1 = 0;
        for (int i = 2 * OSR; i < 3 * OSR; i++) d1 += int'(obs_b1[i]);
        checks++;
        if (d1 < 1 || d1 > 3) begin
            errors++;
            $display("FAIL half_ch1_density got %0d exp 2+-1", d1);
        end
`ifdef PDM_STIM_GEN_ONES_CNT_EN
        checks++;
        if (ones_cnt < 5 || ones_cnt > 7) begin
            errors++;
            $display("FAIL half_ones got %0d exp 6+-1", ones_cnt);
        end
`endif
    endtask

    task automatic test_lfsr();
        do_reset();
        mode = 2'd2;
        obs_s.delete();
        run_rises(3 * OSR);
        checks++;
        if (obs_s.size() != 3 || obs_s[0] !== 16'hE270) begin
            errors++;
            $display("FAIL lfsr_first got %h exp e270", dut.sample_q);
        end
    endtask

    task automatic test_ramp_square();
        run_rises(3);
        mode = 2'd1;
        step = 16'sh1000;
        run_rises(2 * OSR);
        mode = 2'd3;
        level = 16'sh8000;
        run_rises(OSR - 3);
        level = 16'sh7000;
        run_rises(3);
        level = 16'sh8000;
        run_rises(3 * OSR);
    endtask

    task automatic test_freeze();
        logic [31:0] held;
        mode = 2'd0;
        level = 16'sh2000;
        run_rises(3);
        en = 1'b0;
        held = 32'({m_clk, m_data, ones_cnt, dut.div_cnt, dut.rise_cnt});
        for (int i = 0; i < 37; i++) begin
            @(negedge clk);
            checks++;
            if (32'({m_clk, m_data, ones_cnt, dut.div_cnt, dut.rise_cnt}) !== held
                || sample_tick !== 1'b0) begin
                errors++;
                $display("FAIL freeze_hold cyc %0d got %h exp %h", i,
                         32'({m_clk, m_data, ones_cnt, dut.div_cnt, dut.rise_cnt}),
                         held);
            end
        end
        en = 1'b1;
        last_tick = -1;
        run_rises(2 * OSR);
    endtask

    task automatic test_midreset();
        mode = 2'd2;
        run_rises(5);
        checks++;
        if (m_clk !== 1'b1) begin
            errors++;
            $display("FAIL midreset_phase got %b exp 1", m_clk);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if ({m_clk, m_data, sample_tick} !== '0 || ones_cnt !== '0) begin
            errors++;
            $display("FAIL midreset_out got %b/%0d exp 0",
                     {m_clk, m_data, sample_tick}, ones_cnt);
        end
        checks++;
        if (dut.lfsr_q !== 16'hACE1) begin
            errors++;
            $display("FAIL midreset_lfsr got %h exp ace1", dut.lfsr_q);
        end
        model_reset();
        obs_s.delete();
        run_rises(OSR);
        checks++;
        if (obs_s.size() != 1 || obs_s[0] !== 16'hE270) begin
            errors++;
            $display("FAIL midreset_restart got %h exp e270", dut.sample_q);
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_clock();
        test_const_zero();
        test_const_half();
        test_lfsr();
        test_ramp_square();
        test_freeze();
        test_midreset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
